// File: rtl/sdram_arb_pkg.sv
// Shared types and defaults for the SDRAM port arbiter.
// Owner index width helper keeps the picker and the top in agreement.
package sdram_arb_pkg;

    localparam int DEF_ADDR_WIDTH = 23;
    localparam int DEF_DATA_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        REQ        = 2'd1,
        WAIT_VALID = 2'd2
    } state_t;

    function automatic int owner_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational cyclic-priority search: lowest-index requester at or after ptr.
module rr_picker #(
    parameter int NUM_PORTS = 4,
    parameter int IDX_W     = 2
) (
    input  logic [NUM_PORTS-1:0] req,
    input  logic [IDX_W-1:0]     ptr,
    output logic [IDX_W-1:0]     grant,
    output logic                 any
);

    int idx;

    // Walk from the farthest offset down so the nearest requester after ptr wins.
    always_comb begin
        grant = '0;
        any   = |req;
        idx   = 0;
        for (int i = NUM_PORTS - 1; i >= 0; i--) begin
            idx = int'(ptr) + i;
            if (idx >= NUM_PORTS) idx = idx - NUM_PORTS;
            if (req[idx]) grant = IDX_W'(idx);
        end
    end

endmodule

// File: rtl/sdram_arbiter.sv
// Shares one SDRAM controller port between a download writer and NUM_PORTS
// round-robin readers, with a single outstanding transaction at a time.
module sdram_arbiter
    import sdram_arb_pkg::*;
#(
    parameter int NUM_PORTS  = 4,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [ADDR_WIDTH-1:0]           wr_addr,
    input  logic [DATA_WIDTH-1:0]           wr_data,
    input  logic                            wr_req,
    output logic                            wr_ack,
    input  logic [NUM_PORTS*ADDR_WIDTH-1:0] rd_addr,
    input  logic [NUM_PORTS-1:0]            rd_req,
    output logic [NUM_PORTS-1:0]            rd_ack,
    output logic [NUM_PORTS-1:0]            rd_valid,
    output logic [DATA_WIDTH-1:0]           rd_q,
    output logic [ADDR_WIDTH-1:0]           sdram_addr,
    output logic [DATA_WIDTH-1:0]           sdram_data,
    output logic                            sdram_we,
    output logic                            sdram_req,
    input  logic                            sdram_ack,
    input  logic                            sdram_valid,
    input  logic [DATA_WIDTH-1:0]           sdram_q
);

    localparam int IDX_W = owner_w(NUM_PORTS);
    localparam logic [IDX_W-1:0] LAST_PORT = IDX_W'(NUM_PORTS - 1);

    state_t                 state, state_n;
    logic [IDX_W-1:0]       ptr, ptr_n;
    logic [IDX_W-1:0]       owner, owner_n;
    logic                   is_wr, is_wr_n;
    logic [ADDR_WIDTH-1:0]  addr_n;
    logic [DATA_WIDTH-1:0]  data_n;
    logic                   we_n, req_n, wr_ack_n;
    logic [NUM_PORTS-1:0]   rd_ack_n, rd_valid_n;
    logic [DATA_WIDTH-1:0]  rd_q_n;
    logic [IDX_W-1:0]       pick;
    logic                   pick_any;

    rr_picker #(
        .NUM_PORTS (NUM_PORTS),
        .IDX_W     (IDX_W)
    ) u_picker (
        .req   (rd_req),
        .ptr   (ptr),
        .grant (pick),
        .any   (pick_any)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            ptr        <= '0;
            owner      <= '0;
            is_wr      <= 1'b0;
            sdram_addr <= '0;
            sdram_data <= '0;
            sdram_we   <= 1'b0;
            sdram_req  <= 1'b0;
            wr_ack     <= 1'b0;
            rd_ack     <= '0;
            rd_valid   <= '0;
            rd_q       <= '0;
        end else begin
            state      <= state_n;
            ptr        <= ptr_n;
            owner      <= owner_n;
            is_wr      <= is_wr_n;
            sdram_addr <= addr_n;
            sdram_data <= data_n;
            sdram_we   <= we_n;
            sdram_req  <= req_n;
            wr_ack     <= wr_ack_n;
            rd_ack     <= rd_ack_n;
            rd_valid   <= rd_valid_n;
            rd_q       <= rd_q_n;
        end
    end

    always_comb begin
        state_n    = state;
        ptr_n      = ptr;
        owner_n    = owner;
        is_wr_n    = is_wr;
        addr_n     = sdram_addr;
        data_n     = sdram_data;
        we_n       = sdram_we;
        req_n      = sdram_req;
        wr_ack_n   = 1'b0;
        rd_ack_n   = '0;
        rd_valid_n = '0;
        rd_q_n     = rd_q;

        unique case (state)
            IDLE: begin
                // Download writes always win; reads wait until the download stops.
                if (wr_req) begin
                    addr_n  = wr_addr;
                    data_n  = wr_data;
                    we_n    = 1'b1;
                    is_wr_n = 1'b1;
                    req_n   = 1'b1;
                    state_n = REQ;
                end else if (pick_any) begin
                    addr_n  = rd_addr[pick*ADDR_WIDTH +: ADDR_WIDTH];
                    we_n    = 1'b0;
                    is_wr_n = 1'b0;
                    owner_n = pick;
                    req_n   = 1'b1;
                    state_n = REQ;
                end
            end
            REQ: begin
                if (sdram_ack) begin
                    req_n = 1'b0;
                    we_n  = 1'b0;
                    if (is_wr) begin
                        wr_ack_n = 1'b1;
                        state_n  = IDLE;
                    end else begin
                        rd_ack_n[owner] = 1'b1;
                        ptr_n = (owner == LAST_PORT) ? '0 : owner + IDX_W'(1);
                        // Controller may return data in the same cycle it accepts.
                        if (sdram_valid) begin
                            rd_valid_n[owner] = 1'b1;
                            rd_q_n            = sdram_q;
                            state_n           = IDLE;
                        end else begin
                            state_n = WAIT_VALID;
                        end
                    end
                end
            end
            WAIT_VALID: begin
                if (sdram_valid) begin
                    rd_valid_n[owner] = 1'b1;
                    rd_q_n            = sdram_q;
                    state_n           = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

endmodule
